fb_ram_arbiter: RTL and testbench

Shares the single-port 15-bit framebuffer RAM (240x160, one word per pixel, address = line*240 + pixel) between two requesters: the capture writer, which receives pixels from the GBA LCD stream, and the scanout reader, which prefetches pixels for the output display. Read priority is the default so scanout never underruns; a run limit keeps the writer from starving. The block sits between both requesters and the RAM macro.

---
 rtl/fb_ram_arbiter.sv | 151 +++++++++++++++
 tb/tb_fb_ram_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_ram_arbiter.sv
// fb_ram_arbiter: shares the single-port framebuffer RAM between the capture
// writer and the scanout reader. Reads win by default so scanout never
// underruns. After MAX_RD_RUN consecutive reads granted against a waiting
// writer, the writer gets one forced slot.
// Optional build macro FB_RAM_ARB_STATS_EN adds the o_wr_stall_cnt output.
module fb_ram_arbiter #(
  parameter int FB_WORDS   = 38400,
  parameter int RD_LATENCY = 1,
  parameter int MAX_RD_RUN = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [15:0] i_wr_addr,
  input  logic [14:0] i_wr_data,
  input  logic        i_rd_valid,
  output logic        o_rd_ready,
  input  logic [15:0] i_rd_addr,
  output logic [14:0] o_rd_data,
  output logic        o_rd_data_valid,
  output logic [15:0] o_ram_addr,
  output logic        o_ram_we,
  output logic [14:0] o_ram_wdata,
  input  logic [14:0] i_ram_rdata,
  input  logic        i_clr_oob,
`ifdef FB_RAM_ARB_STATS_EN
  output logic [15:0] o_wr_stall_cnt,
`endif
  output logic        o_oob
);

  localparam logic [3:0]  RUN_MAX  = 4'(MAX_RD_RUN);
  localparam logic [16:0] FB_LIMIT = 17'(FB_WORDS);

  // Reads granted back-to-back while the writer was waiting.
  logic [3:0] run_cnt;
  logic [3:0] run_cnt_nxt;
  logic       at_limit;

  logic wr_hs;
  logic rd_hs;
  logic wr_oob;
  logic rd_oob;

  // One bit per cycle of read latency. Each bit marks a read that is in
  // flight, and a second bit marks whether that read was out of range.
  logic [RD_LATENCY:0] rv_pipe;
  logic [RD_LATENCY:0] ro_pipe;

  assign at_limit = (run_cnt == RUN_MAX);
  assign wr_hs    = i_wr_valid & o_wr_ready;
  assign rd_hs    = i_rd_valid & o_rd_ready;
  assign wr_oob   = ({1'b0, i_wr_addr} >= FB_LIMIT);
  assign rd_oob   = ({1'b0, i_rd_addr} >= FB_LIMIT);

  // State register: the run counter is the whole arbitration state.
  // IDLE: nobody is granted. RD_RUN: the counter is counting.
  // WR_FORCE: the counter is at its limit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop then
      // samples the values from before the edge, whatever the process order.
      run_cnt <= run_cnt_nxt;
    end
  end

  // Next state: count reads that a waiting writer loses. Clear the count on
  // a write grant, or when the writer is not asking.
  always_comb begin
    // NOTE: the default is assigned first so that every path drives the
    // signal. A path that left it undriven would infer a latch.
    run_cnt_nxt = '0;
    if (i_wr_valid && rd_hs) begin
      run_cnt_nxt = run_cnt + 4'd1;
    end
  end

  // Output decode: the grants depend only on the valids and on run_cnt.
  always_comb begin
    o_wr_ready = 1'b0;
    o_rd_ready = 1'b0;
    if (i_wr_valid && (!i_rd_valid || at_limit)) begin
      o_wr_ready = 1'b1;
    end else if (i_rd_valid) begin
      o_rd_ready = 1'b1;
    end
  end

  // RAM command register. An out-of-range request is accepted but never
  // reaches the RAM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ram_addr  <= '0;
      o_ram_we    <= 1'b0;
      o_ram_wdata <= '0;
    end else begin
      o_ram_we <= 1'b0;
      if (wr_hs && !wr_oob) begin
        o_ram_we    <= 1'b1;
        o_ram_addr  <= i_wr_addr;
        o_ram_wdata <= i_wr_data;
      end else if (rd_hs && !rd_oob) begin
        o_ram_addr <= i_rd_addr;
      end
    end
  end

  // Read-return pipeline. Slot RD_LATENCY lines up with the RAM data of that
  // read, so back-to-back reads come back in order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rv_pipe <= '0;
      ro_pipe <= '0;
    end else begin
      rv_pipe <= {rv_pipe[RD_LATENCY-1:0], rd_hs};
      ro_pipe <= {ro_pipe[RD_LATENCY-1:0], rd_hs & rd_oob};
    end
  end

  assign o_rd_data_valid = rv_pipe[RD_LATENCY];
  assign o_rd_data       = (rv_pipe[RD_LATENCY] && !ro_pipe[RD_LATENCY]) ? i_ram_rdata : '0;

  // Sticky out-of-range flag. A new hit wins over a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_oob <= 1'b0;
    end else if ((wr_hs && wr_oob) || (rd_hs && rd_oob)) begin
      o_oob <= 1'b1;
    end else if (i_clr_oob) begin
      o_oob <= 1'b0;
    end
  end

`ifdef FB_RAM_ARB_STATS_EN
  // Saturating count of cycles in which the writer waited. A clear wins over
  // an increment in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_stall_cnt <= '0;
    end else if (i_clr_oob) begin
      o_wr_stall_cnt <= '0;
    end else if (i_wr_valid && !o_wr_ready && (o_wr_stall_cnt != 16'hFFFF)) begin
      o_wr_stall_cnt <= o_wr_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_ram_arbiter.sv
// tb_fb_ram_arbiter: self-checking bench for fb_ram_arbiter. Directed scenes
// are followed by a randomized phase. A behavioural RAM sits behind the DUT,
// and a transaction-level reference model predicts every output.
module tb_fb_ram_arbiter;

  localparam int FB_WORDS   = 38400;
  localparam int RD_LATENCY = 1;
  localparam int MAX_RD_RUN = 4;
  localparam int MEM_WORDS  = 256;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [14:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_addr;
  logic [14:0] rd_data;
  logic        rd_data_valid;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [14:0] ram_wdata;
  logic [14:0] ram_rdata;
  logic        clr_oob;
  logic        oob;
`ifdef FB_RAM_ARB_STATS_EN
  logic [15:0] wr_stall_cnt;
`endif

  fb_ram_arbiter #(
    .FB_WORDS  (FB_WORDS),
    .RD_LATENCY(RD_LATENCY),
    .MAX_RD_RUN(MAX_RD_RUN)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_wr_valid     (wr_valid),
    .o_wr_ready     (wr_ready),
    .i_wr_addr      (wr_addr),
    .i_wr_data      (wr_data),
    .i_rd_valid     (rd_valid),
    .o_rd_ready     (rd_ready),
    .i_rd_addr      (rd_addr),
    .o_rd_data      (rd_data),
    .o_rd_data_valid(rd_data_valid),
    .o_ram_addr     (ram_addr),
    .o_ram_we       (ram_we),
    .o_ram_wdata    (ram_wdata),
    .i_ram_rdata    (ram_rdata),
    .i_clr_oob      (clr_oob),
`ifdef FB_RAM_ARB_STATS_EN
    .o_wr_stall_cnt (wr_stall_cnt),
`endif
    .o_oob          (oob)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port RAM. It has a registered read path of RD_LATENCY
  // stages and covers only the low MEM_WORDS addresses.
  logic [14:0] ram [MEM_WORDS];
  logic [14:0] ram_pipe [RD_LATENCY];

  always @(posedge clk) begin
    if (int'(ram_addr) < MEM_WORDS) begin
      if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;
      ram_pipe[0] <= ram[ram_addr[7:0]];
    end else begin
      ram_pipe[0] <= '0;
    end
    for (int i = 1; i < RD_LATENCY; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign ram_rdata = ram_pipe[RD_LATENCY-1];

  // Reference model state, expressed as transactions and their visible effects.
  typedef struct {
    int          due;
    logic [14:0] data;
  } ret_t;

  ret_t        ret_q[$];
  logic [14:0] m_mem [MEM_WORDS];
  int          m_streak;
  logic [15:0] m_addr;
  logic        m_we;
  logic [14:0] m_wdata;
  logic        m_oob;
  int          m_stall;
  int          cyc;

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    ret_q.delete();
    m_streak = 0;
    m_addr   = '0;
    m_we     = 1'b0;
    m_wdata  = '0;
    m_oob    = 1'b0;
    m_stall  = 0;
  endtask

  // Assert reset for one clock edge and check that every output is cleared.
  task automatic do_reset();
    wr_valid = 1'b0; rd_valid = 1'b0; clr_oob = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    rst_n = 1'b0;
    #3;
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_rd_valid", 32'(rd_data_valid), 32'd0);
    check("rst_oob", 32'(oob), 32'd0);
`ifdef FB_RAM_ARB_STATS_EN
    check("rst_stall", 32'(wr_stall_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    cyc++;
  endtask

  // Drive one cycle, compare all outputs against the model, then advance the
  // model by one cycle.
  task automatic step(input logic wv, input logic [15:0] wa, input logic [14:0] wd,
                      input logic rv, input logic [15:0] ra, input logic clr);
    logic g_wr, g_rd, hit;
    logic [14:0] rdat;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra; clr_oob = clr;
    #3;
    // Reads have priority unless the writer has already lost MAX_RD_RUN in a row.
    g_wr = wv && (!rv || (m_streak == MAX_RD_RUN));
    g_rd = rv && !g_wr;
    check("wr_ready", 32'(wr_ready), 32'(g_wr));
    check("rd_ready", 32'(rd_ready), 32'(g_rd));
    check("ram_we", 32'(ram_we), 32'(m_we));
    check("ram_addr", 32'(ram_addr), 32'(m_addr));
    check("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
    check("oob", 32'(oob), 32'(m_oob));
`ifdef FB_RAM_ARB_STATS_EN
    check("stall_cnt", 32'(wr_stall_cnt), 32'(m_stall));
`endif
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      check("rd_valid", 32'(rd_data_valid), 32'd1);
      check("rd_data", 32'(rd_data), 32'(ret_q[0].data));
      void'(ret_q.pop_front());
    end else begin
      check("rd_valid_idle", 32'(rd_data_valid), 32'd0);
    end

    m_we = 1'b0;
    hit  = 1'b0;
    if (g_wr) begin
      if (int'(wa) >= FB_WORDS) hit = 1'b1;
      else begin
        m_we = 1'b1; m_addr = wa; m_wdata = wd;
        if (int'(wa) < MEM_WORDS) m_mem[wa[7:0]] = wd;
      end
    end
    if (g_rd) begin
      if (int'(ra) >= FB_WORDS) begin
        hit  = 1'b1;
        rdat = '0;
      end else begin
        m_addr = ra;
        rdat   = m_mem[ra[7:0]];
      end
      ret_q.push_back('{due: cyc + 1 + RD_LATENCY, data: rdat});
    end
    m_streak = (g_rd && wv) ? m_streak + 1 : 0;
    if (clr) m_stall = 0;
    else if (wv && !g_wr && m_stall < 65535) m_stall++;
    if (hit) m_oob = 1'b1;
    else if (clr) m_oob = 1'b0;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic        wv, rv, clr;
    logic [15:0] wa, ra;
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    wr_valid = 1'b0; rd_valid = 1'b0; clr_oob = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = '0;
    #1;
    do_reset();

    // Write-only stream over one display line.
    for (int i = 0; i < 240; i++) step(1'b1, 16'(i), 15'h03E0, 1'b0, '0, 1'b0);
    idle(1);

    // Load distinct words, then read them back-to-back.
    step(1'b1, 16'd0, 15'h1234, 1'b0, '0, 1'b0);
    step(1'b1, 16'd1, 15'h2345, 1'b0, '0, 1'b0);
    step(1'b1, 16'd2, 15'h3456, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 16'(i), 1'b0);
    idle(RD_LATENCY + 2);

    // Both requesters asking all the time: the grants settle into R,R,R,R,W.
    for (int i = 0; i < 15; i++) step(1'b1, 16'(10 + i), 15'(i * 3), 1'b1, 16'(100 + i), 1'b0);
    idle(RD_LATENCY + 2);

    // Out-of-range read and write, plus a write at the last legal word.
    step(1'b0, '0, '0, 1'b1, 16'd38400, 1'b0);
    step(1'b1, 16'd40000, 15'h7FFF, 1'b0, '0, 1'b0);
    step(1'b1, 16'd38399, 15'h0ABC, 1'b0, '0, 1'b0);
    idle(RD_LATENCY + 2);
    check("oob_sticky", 32'(oob), 32'd1);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1);
    check("oob_cleared", 32'(oob), 32'd0);
    idle(1);

    // A reset between a read handshake and its return drops the return.
    step(1'b0, '0, '0, 1'b1, 16'd5, 1'b0);
    do_reset();
    step(1'b0, '0, '0, 1'b1, 16'd6, 1'b0);
    idle(RD_LATENCY + 2);

    // Stall count over ten cycles with both requesters asking.
    step(1'b0, '0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 16'(50 + i), 15'(i), 1'b1, 16'(60 + i), 1'b0);
`ifdef FB_RAM_ARB_STATS_EN
    check("stall_after_10", 32'(wr_stall_cnt), 32'd8);
`endif
    idle(RD_LATENCY + 2);

    // Randomized traffic: mostly in range, with occasional out-of-range
    // addresses and clears.
    for (int i = 0; i < 1500; i++) begin
      wv  = ($urandom_range(3) != 0);
      rv  = ($urandom_range(3) != 0);
      clr = ($urandom_range(19) == 0);
      wa  = ($urandom_range(9) == 0) ? 16'($urandom_range(65535, FB_WORDS)) : 16'($urandom_range(239));
      ra  = ($urandom_range(9) == 0) ? 16'($urandom_range(65535, FB_WORDS)) : 16'($urandom_range(239));
      step(wv, wa, 15'($urandom), rv, ra, clr);
    end
    idle(RD_LATENCY + 3);
    check("returns_drained", 32'(ret_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
